// File: rtl/dance_pkg.sv
// Shared types and helpers for the dance-game music path.
package dance_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EASY   = 2'd0,
    MED    = 2'd1,
    HARD   = 2'd2,
    EXPERT = 2'd3
  } diff_e;

  // Smallest n with 2^n >= v.
  function automatic int clog2(input longint unsigned v);
    int n;
    longint unsigned p;
    n = 0;
    p = 64'd1;
    while (p < v) begin
      p = p << 1;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// Control/status bundle between the top-level switches and the beat sequencer.
interface beat_sequencer_if #(
  parameter int BPM_W           = 16,
  parameter int BEAT_W          = 10,
  parameter int SONG_W          = 2,
  parameter int MAX_SUBDIV_LOG2 = 3
);
  logic                       play;
  logic [BPM_W-1:0]           bpm;
  logic [1:0]                 difficulty;
  logic [SONG_W-1:0]          song_sel;
  logic [BEAT_W-1:0]          song_len;
  logic                       tick_pulse;
  logic                       beat_pulse;
  logic [MAX_SUBDIV_LOG2-1:0] tick_in_beat;
  logic [BEAT_W-1:0]          beat_count;
  logic [SONG_W-1:0]          song_id;
  logic                       playing;
  logic                       paused;
  logic                       done;
  logic                       bpm_err;

  modport master (
    output play, bpm, difficulty, song_sel, song_len,
    input  tick_pulse, beat_pulse, tick_in_beat, beat_count, song_id,
           playing, paused, done, bpm_err
  );

  modport slave (
    input  play, bpm, difficulty, song_sel, song_len,
    output tick_pulse, beat_pulse, tick_in_beat, beat_count, song_id,
           playing, paused, done, bpm_err
  );
endinterface

// File: rtl/beat_sequencer_phase_acc.sv
// Divider-free tempo generator: adds bpm<<diff per cycle, ticks on crossing CLK_HZ*60.
module bpm_phase_accumulator
  import dance_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int BPM_W           = 16,
  parameter int MAX_SUBDIV_LOG2 = 3,
  parameter int ACC_W           = 34
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [BPM_W-1:0] i_bpm,
  input  logic [1:0]       i_diff,
  output logic             o_fire,
  output logic             o_tick
);
  localparam int              INC_W   = BPM_W + MAX_SUBDIV_LOG2;
  localparam longint unsigned T_FULL  = 64'(CLK_HZ) * 64'd60;
  localparam longint unsigned INC_MAX = ((64'd1 << BPM_W) - 64'd1) << MAX_SUBDIV_LOG2;
  localparam logic [ACC_W-1:0] T      = ACC_W'(T_FULL);

  if (ACC_W < clog2(T_FULL + INC_MAX)) begin : g_acc_w_chk
    $error("ACC_W too narrow for CLK_HZ*60 plus the largest increment");
  end

  logic [ACC_W-1:0] r_acc, w_sum;
  logic [INC_W-1:0] r_inc;
  logic             r_tick, w_ovf;

  assign w_sum  = r_acc + ACC_W'(r_inc);
  assign w_ovf  = (w_sum >= T);
  assign o_fire = i_en & w_ovf;
  assign o_tick = r_tick;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc  <= '0;
      r_inc  <= '0;
      r_tick <= 1'b0;
    end else if (i_clear) begin
      r_acc  <= '0;
      r_inc  <= INC_W'(i_bpm) << i_diff;
      r_tick <= 1'b0;
    end else begin
      r_tick <= o_fire;
      if (i_en) r_acc <= w_ovf ? (w_sum - T) : w_sum;
    end
  end
endmodule

// File: rtl/beat_sequencer.sv
// Tempo/beat engine: start/pause/resume/done FSM plus subdivision and beat counters.
module beat_sequencer
  import dance_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int BPM_W           = 16,
  parameter int BEAT_W          = 10,
  parameter int SONG_W          = 2,
  parameter int MAX_SUBDIV_LOG2 = 3,
  parameter int ACC_W           = 34
) (
  input  logic             clk,
  input  logic             resetn,
  beat_sequencer_if.slave  bus
);
  localparam int SL = MAX_SUBDIV_LOG2;

  state_e            r_state, w_state_nxt;
  logic              r_play_q, w_rise, w_valid, w_start, w_en, w_fire, w_tick;
  logic              w_wrap, w_last_beat, r_beat_pulse, r_err;
  logic [1:0]        r_diff, w_diff_c;
  logic [SONG_W-1:0] r_song;
  logic [BEAT_W-1:0] r_len, r_beat_count, w_bc_inc;
  logic [SL-1:0]     r_tib, w_last_tib;
  logic [SL:0]       w_span, w_span_m1;

  assign w_rise      = bus.play & ~r_play_q;
  assign w_valid     = (bus.bpm != '0) && (bus.song_len != '0);
  assign w_start     = (r_state == IDLE) && w_rise && w_valid;
  assign w_en        = (r_state == PLAYING) && bus.play;
  assign w_diff_c    = (int'(bus.difficulty) > SL) ? 2'(SL) : bus.difficulty;
  assign w_span      = (SL+1)'(1) << r_diff;
  assign w_span_m1   = w_span - 1'b1;
  assign w_last_tib  = w_span_m1[SL-1:0];
  assign w_wrap      = (r_tib == w_last_tib);
  assign w_bc_inc    = r_beat_count + 1'b1;
  assign w_last_beat = w_fire && w_wrap && (w_bc_inc == r_len);

  bpm_phase_accumulator #(
    .CLK_HZ(CLK_HZ), .BPM_W(BPM_W), .MAX_SUBDIV_LOG2(SL), .ACC_W(ACC_W)
  ) u_acc (
    .clk(clk), .resetn(resetn), .i_en(w_en), .i_clear(w_start),
    .i_bpm(bus.bpm), .i_diff(w_diff_c), .o_fire(w_fire), .o_tick(w_tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = PLAYING;
      PLAYING: if (!bus.play) w_state_nxt = PAUSED;
               else if (w_last_beat) w_state_nxt = DONE;
      PAUSED:  if (bus.play) w_state_nxt = PLAYING;
      DONE:    if (!bus.play) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.playing = (r_state == PLAYING);
    bus.paused  = (r_state == PAUSED);
    bus.done    = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Previous-play history resets high so a play level held through reset is not a start.
      r_play_q     <= 1'b1;
      r_diff       <= '0;
      r_song       <= '0;
      r_len        <= '0;
      r_tib        <= '0;
      r_beat_count <= '0;
      r_beat_pulse <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_play_q     <= bus.play;
      r_beat_pulse <= w_fire & w_wrap;
      if ((r_state == IDLE) && w_rise) r_err <= ~w_valid;
      if (w_start) begin
        r_diff       <= w_diff_c;
        r_song       <= bus.song_sel;
        r_len        <= bus.song_len;
        r_tib        <= '0;
        r_beat_count <= '0;
      end else if (w_fire) begin
        r_tib <= w_wrap ? '0 : r_tib + 1'b1;
        if (w_wrap) r_beat_count <= w_bc_inc;
      end
    end
  end

  assign bus.tick_pulse   = w_tick;
  assign bus.beat_pulse   = r_beat_pulse;
  assign bus.tick_in_beat = r_tib;
  assign bus.beat_count   = r_beat_count;
  assign bus.song_id      = r_song;
  assign bus.bpm_err      = r_err;
endmodule
